// File: rtl/spram_arbiter_if.sv
// Bundle of requester A/B, SPRAM and status signals shared by spram_arbiter and its clients.
// The slave modport is the arbiter's view; master is the client/memory side.
interface spram_arbiter_if #(
   parameter int ADDR_SZ = 14,
   parameter int DATA_SZ = 16
);
   logic               o_ready;

   logic               i_a_req;
   logic               i_a_wr;
   logic [ADDR_SZ-1:0] i_a_addr;
   logic [DATA_SZ-1:0] i_a_wdata;
   logic [3:0]         i_a_wmask;
   logic               o_a_ack;
   logic               o_a_rvalid;
   logic [DATA_SZ-1:0] o_a_rdata;

   logic               i_b_req;
   logic               i_b_wr;
   logic [ADDR_SZ-1:0] i_b_addr;
   logic [DATA_SZ-1:0] i_b_wdata;
   logic [3:0]         i_b_wmask;
   logic               o_b_ack;
   logic               o_b_rvalid;
   logic [DATA_SZ-1:0] o_b_rdata;

   logic               o_mem_cs;
   logic               o_mem_we;
   logic [ADDR_SZ-1:0] o_mem_addr;
   logic [DATA_SZ-1:0] o_mem_wdata;
   logic [3:0]         o_mem_maskwe;
   logic [DATA_SZ-1:0] i_mem_rdata;

   modport slave (
      output o_ready,
      input  i_a_req, i_a_wr, i_a_addr, i_a_wdata, i_a_wmask,
      output o_a_ack, o_a_rvalid, o_a_rdata,
      input  i_b_req, i_b_wr, i_b_addr, i_b_wdata, i_b_wmask,
      output o_b_ack, o_b_rvalid, o_b_rdata,
      output o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_maskwe,
      input  i_mem_rdata
   );

   modport master (
      input  o_ready,
      output i_a_req, i_a_wr, i_a_addr, i_a_wdata, i_a_wmask,
      input  o_a_ack, o_a_rvalid, o_a_rdata,
      output i_b_req, i_b_wr, i_b_addr, i_b_wdata, i_b_wmask,
      input  o_b_ack, o_b_rvalid, o_b_rdata,
      input  o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_maskwe,
      output i_mem_rdata
   );
endinterface

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read) between
// two req/ack requesters, with a start-up delay before the first grant.
module spram_arbiter #(
   parameter int INIT_CYCLES = 64,
   parameter int ADDR_SZ     = 14,
   parameter int DATA_SZ     = 16
) (
   input logic              i_clk,
   input logic              i_rst_n,
   spram_arbiter_if.slave   bus
);
   localparam int CNT_W = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] INIT_LAST = (INIT_CYCLES > 0) ? CNT_W'(INIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS} state_e;
   typedef enum logic       {PORT_A, PORT_B} port_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   port_e              last_q, last_d;
   port_e              grant;
   logic               ready_q, ready_d;
   logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic               a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
   logic               cs_q, cs_d, we_q, we_d;
   logic [ADDR_SZ-1:0] addr_q, addr_d;
   logic [DATA_SZ-1:0] wdata_q, wdata_d;
   logic [3:0]         mask_q, mask_d;

   // Contention goes to the port that did not win last; a lone requester always wins.
   assign grant = (bus.i_a_req && (!bus.i_b_req || last_q == PORT_B)) ? PORT_A : PORT_B;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      ready_d    = ready_q;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_rvalid_d = 1'b0;
      b_rvalid_d = 1'b0;
      cs_d       = 1'b0;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;

      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (INIT_CYCLES == 0 || cnt_q == INIT_LAST) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (bus.i_a_req || bus.i_b_req) begin
               state_d = ST_ACCESS;
               last_d  = grant;
               cs_d    = 1'b1;
               if (grant == PORT_A) begin
                  a_ack_d = 1'b1;
                  we_d    = bus.i_a_wr;
                  addr_d  = bus.i_a_addr;
                  wdata_d = bus.i_a_wdata;
                  mask_d  = bus.i_a_wmask;
               end else begin
                  b_ack_d = 1'b1;
                  we_d    = bus.i_b_wr;
                  addr_d  = bus.i_b_addr;
                  wdata_d = bus.i_b_wdata;
                  mask_d  = bus.i_b_wmask;
               end
            end
         end
         ST_ACCESS: begin
            // The RAM returns read data one cycle after the command; flag it for the owner.
            state_d    = ST_IDLE;
            a_rvalid_d = !we_q && (last_q == PORT_A);
            b_rvalid_d = !we_q && (last_q == PORT_B);
         end
         default: state_d = ST_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         last_q     <= PORT_B;
         ready_q    <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         ready_q    <= ready_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         cs_q       <= cs_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
      end
   end

   assign bus.o_ready      = ready_q;
   assign bus.o_a_ack      = a_ack_q;
   assign bus.o_b_ack      = b_ack_q;
   assign bus.o_a_rvalid   = a_rvalid_q;
   assign bus.o_b_rvalid   = b_rvalid_q;
   assign bus.o_a_rdata    = bus.i_mem_rdata;
   assign bus.o_b_rdata    = bus.i_mem_rdata;
   assign bus.o_mem_cs     = cs_q;
   assign bus.o_mem_we     = we_q;
   assign bus.o_mem_addr   = addr_q;
   assign bus.o_mem_wdata  = wdata_q;
   assign bus.o_mem_maskwe = mask_q;
endmodule
